ly_pulse_injector: RTL and testbench
====================================

// Module: ly_pulse_injector
// PURPOSE
//  Test-pulse source for one anode layer: drives a programmed 32-wire hit pattern as clean,
//  fixed-width pulses into the layer one-shot chain. Produces a burst of N pulses, each followed
//  by a programmable gap, under a start/busy/done handshake. Pulse starts are gated by trig_stop.
//  Sits between the slow-control test registers and the layer input mux, ahead of the one-shots.
// PARAMETERS
//  WIDTH  32  wires per layer (width of pattern and ly)
//  CNT_W  8   width of gap_len, repeat_n and pulse_cnt
//  LEN_W  4   width of pulse_len
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request a burst; sampled only in IDLE
//  pattern    in   WIDTH  wires to fire; latched on accepted start
//  pulse_len  in   LEN_W  pulse width in clocks; 0 treated as 1; latched on start
//  gap_len    in   CNT_W  low clocks between pulses; 0 treated as 1; latched on start
//  repeat_n   in   CNT_W  number of pulses in burst; latched on start
//  trig_stop  in   1      when high, no new pulse may begin
//  ly         out  WIDTH  injected layer pattern (registered)
//  busy       out  1      burst in progress
//  done       out  1      one-clock strobe: burst complete
//  pulse_cnt  out  CNT_W  pulses fully emitted in current/last burst
// BEHAVIOUR
//  - Reset: ly=0, busy=0, done=0, pulse_cnt=0, state=IDLE. rst overrides every other input,
//    incl. mid-pulse: ly drops to 0 at the reset edge, no done strobe issued.
//  - All outputs are registered; no combinational input->output path.
//  - States: IDLE, ARM, PULSE, GAP.
//  - IDLE: start=1 at edge N -> latch inputs, pulse_cnt=0, busy=1 from N+1.
//    If repeat_n==0 -> stay IDLE, busy=0, done=1 for cycle N+1 only, ly stays 0.
//    Else -> ARM.
//  - ARM: ly=0. trig_stop=0 -> PULSE, ly=pattern from next cycle; trig_stop=1 -> hold in ARM.
//    Nominal latency start edge -> first ly high = 2 clocks.
//  - PULSE: ly=latched pattern for exactly max(pulse_len,1) clocks; trig_stop ignored (a started
//    pulse always completes). At end: pulse_cnt+1; if pulse_cnt+1==repeat_n -> IDLE with ly=0,
//    busy=0, done=1 for one clock (no trailing gap); else -> GAP.
//  - GAP: ly=0 for max(gap_len,1) clocks, then -> ARM (trig_stop re-checked there). A gap of at
//    least 1 clock plus 1 ARM clock guarantees a falling and rising edge between pulses.
//  - start while busy (ARM/PULSE/GAP) ignored; not queued. start in the done cycle is accepted.
//  - pattern==0 is legal: burst timing, busy, done, pulse_cnt run normally, ly stays 0.
//  - Changes on pattern/lengths/repeat_n after start have no effect until next accepted start.
//  - pulse_cnt holds its final value after done until next accepted start; no wrap
//    (max repeat_n = 2^CNT_W-1).
// STRUCTURE
//  - Shared package ly_inj_pkg: state enum (IDLE/ARM/PULSE/GAP), default WIDTH/CNT_W/LEN_W.
//  - One sub-module ly_inj_timer: loadable down-counter (load, value, en, zero flag), used once
//    for pulse width and once for gap width; FSM, latches and pulse_cnt in top level.
// TESTING
//  - rst held 3 clks, then idle: ly=0, busy=0, done=0, pulse_cnt=0 every cycle.
//  - pattern=32'hA5A5_0001, pulse_len=3, gap_len=2, repeat_n=2, trig_stop=0 -> ly=pattern
//    cycles 2-4 and 8-10 after start edge, 0 elsewhere; done=1 at cycle 11; pulse_cnt=2.
//  - repeat_n=0 -> done=1 one clock after start, busy never high, ly always 0.
//  - pulse_len=0, gap_len=0, repeat_n=3 -> three 1-clk pulses spaced by 1 gap + 1 ARM clk.
//  - trig_stop=1 during start and for 5 clks -> busy=1, ly=0, held in ARM; pulse begins
//    1 clk after trig_stop falls; trig_stop rising mid-pulse does not shorten pulse.
//  - rst asserted in 2nd clk of a pulse -> ly=0, busy=0 next edge, no done; start during
//    busy ignored; start in the done cycle begins a new burst.

Source files
------------

// File: rtl/ly_inj_pkg.sv
// Shared constants for the anode-layer test-pulse injector: default widths and FSM state codes.
package ly_inj_pkg;

  localparam int LY_WIDTH = 32;
  localparam int LY_CNT_W = 8;
  localparam int LY_LEN_W = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/ly_inj_timer.sv
// Loadable down-counter; zero_o flags the last clock of an interval loaded as (length-1).
module ly_inj_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         zero_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                    cnt_q <= '0;
    else if (load_i)              cnt_q <= value_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - ONE;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ly_pulse_injector.sv
// Test-pulse source for one anode layer: bursts of fixed-width pattern pulses separated by gaps,
// with a start/busy/done handshake and trig_stop gating of new pulse starts.
module ly_pulse_injector
  import ly_inj_pkg::*;
#(
  parameter int WIDTH = LY_WIDTH,
  parameter int CNT_W = LY_CNT_W,
  parameter int LEN_W = LY_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LEN_W-1:0] pulse_len_i,
  input  logic [CNT_W-1:0] gap_len_i,
  input  logic [CNT_W-1:0] repeat_n_i,
  input  logic             trig_stop_i,
  output logic [WIDTH-1:0] ly_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pulse_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d, ly_q, ly_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic [CNT_W-1:0] glen_q, glen_d, rep_q, rep_d, cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             p_load, p_en, p_zero, g_load, g_en, g_zero;
  logic [LEN_W-1:0] p_val;
  logic [CNT_W-1:0] g_val, cnt_inc;

  // Timers count (len-1)..0 so a zero length behaves as one clock.
  assign p_val   = (plen_q == '0) ? '0 : plen_q - LEN_ONE;
  assign g_val   = (glen_q == '0) ? '0 : glen_q - CNT_ONE;
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    plen_d  = plen_q;
    glen_d  = glen_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ly_d    = '0;
    p_load  = 1'b0;
    p_en    = 1'b0;
    g_load  = 1'b0;
    g_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pat_d  = pattern_i;
          plen_d = pulse_len_i;
          glen_d = gap_len_i;
          rep_d  = repeat_n_i;
          cnt_d  = '0;
          if (repeat_n_i == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (!trig_stop_i) begin
          state_d = ST_PULSE;
          ly_d    = pat_q;
          p_load  = 1'b1;
        end
      end
      ST_PULSE: begin
        if (p_zero) begin
          cnt_d = cnt_inc;
          if (cnt_inc == rep_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            g_load  = 1'b1;
          end
        end else begin
          ly_d = pat_q;
          p_en = 1'b1;
        end
      end
      default: begin
        if (g_zero) state_d = ST_ARM;
        else        g_en    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      plen_q  <= '0;
      glen_q  <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ly_q    <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      plen_q  <= plen_d;
      glen_q  <= glen_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ly_q    <= ly_d;
    end
  end

  ly_inj_timer #(.W(LEN_W)) u_pulse_tmr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (p_load),
    .value_i (p_val),
    .en_i    (p_en),
    .zero_o  (p_zero)
  );

  ly_inj_timer #(.W(CNT_W)) u_gap_tmr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (g_load),
    .value_i (g_val),
    .en_i    (g_en),
    .zero_o  (g_zero)
  );

  assign ly_o        = ly_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pulse_cnt_o = cnt_q;

endmodule

// File: tb/tb_ly_pulse_injector.sv
// Directed bench for ly_pulse_injector: inputs driven and outputs sampled on the falling edge.
module tb_ly_pulse_injector;

  logic        clk = 1'b0;
  logic        rst, start, trig_stop;
  logic [31:0] pattern;
  logic [3:0]  pulse_len;
  logic [7:0]  gap_len, repeat_n;
  logic [31:0] ly;
  logic        busy, done;
  logic [7:0]  pulse_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ly_pulse_injector dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .pattern_i   (pattern),
    .pulse_len_i (pulse_len),
    .gap_len_i   (gap_len),
    .repeat_n_i  (repeat_n),
    .trig_stop_i (trig_stop),
    .ly_o        (ly),
    .busy_o      (busy),
    .done_o      (done),
    .pulse_cnt_o (pulse_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input int k, input logic [31:0] el,
                      input logic eb, input logic ed);
    chk($sformatf("%s.c%0d.ly", tag, k), 64'(ly), 64'(el));
    chk($sformatf("%s.c%0d.busy", tag, k), 64'(busy), 64'(eb));
    chk($sformatf("%s.c%0d.done", tag, k), 64'(done), 64'(ed));
  endtask

  task automatic arm_burst(input logic [31:0] p, input logic [3:0] pl,
                           input logic [7:0] gl, input logic [7:0] rn);
    @(negedge clk);
    pattern   = p;
    pulse_len = pl;
    gap_len   = gl;
    repeat_n  = rn;
    start     = 1'b1;
  endtask

  localparam logic [31:0] P1 = 32'hA5A5_0001;
  localparam logic [31:0] P2 = 32'hFFFF_0000;
  localparam logic [31:0] P3 = 32'h0F0F_F0F0;
  localparam logic [31:0] P4 = 32'h1234_5678;

  initial begin
    rst = 1'b1; start = 1'b0; trig_stop = 1'b0;
    pattern = '0; pulse_len = '0; gap_len = '0; repeat_n = '0;

    // reset held 3 clocks, then idle
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      look("rst", k, '0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      look("idle", k, '0, 1'b0, 1'b0);
      chk($sformatf("idle.c%0d.cnt", k), 64'(pulse_cnt), 64'd0);
    end

    // nominal burst; inputs scrambled after start must not matter
    arm_burst(P1, 4'd3, 8'd2, 8'd2);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; pattern = '0; pulse_len = 4'd9; gap_len = 8'd7; repeat_n = 8'd5;
      end
      look("nom", k, ((k >= 2 && k <= 4) || (k >= 8 && k <= 10)) ? P1 : '0, k <= 10, k == 11);
      if (k == 5)  chk("nom.cnt5", 64'(pulse_cnt), 64'd1);
      if (k == 12) chk("nom.cnt12", 64'(pulse_cnt), 64'd2);
    end

    // repeat_n==0: done strobe only
    arm_burst(P1, 4'd3, 8'd2, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      look("rep0", k, '0, 1'b0, k == 1);
      chk($sformatf("rep0.c%0d.cnt", k), 64'(pulse_cnt), 64'd0);
    end

    // zero lengths treated as one clock
    arm_burst(P2, 4'd0, 8'd0, 8'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      look("zlen", k, (k == 2 || k == 5 || k == 8) ? P2 : '0, k <= 8, k == 9);
      if (k == 10) chk("zlen.cnt", 64'(pulse_cnt), 64'd3);
    end

    // trig_stop holds ARM; rising mid-pulse does not shorten pulse
    trig_stop = 1'b1;
    arm_burst(P3, 4'd4, 8'd1, 8'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      look("trig", k, (k >= 6 && k <= 9) ? P3 : '0, k <= 9, k == 10);
      if (k == 5) trig_stop = 1'b0;
      if (k == 7) trig_stop = 1'b1;
    end
    trig_stop = 1'b0;

    // reset in 2nd clock of a pulse
    arm_burst(P1, 4'd5, 8'd1, 8'd2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      look("mrst", k, (k >= 2) ? P1 : '0, 1'b1, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    look("mrst", 4, '0, 1'b0, 1'b0);
    chk("mrst.cnt", 64'(pulse_cnt), 64'd0);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      look("mrst", k, '0, 1'b0, 1'b0);
    end

    // start while busy ignored; start in done cycle accepted
    arm_burst(P3, 4'd2, 8'd1, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      look("hs", k, (k == 2 || k == 3) ? P3 : (k == 6) ? P4 : '0,
           (k >= 1 && k <= 3) || (k == 5 || k == 6), k == 4 || k == 7);
      if (k == 4) chk("hs.cnt4", 64'(pulse_cnt), 64'd1);
      if (k == 5) chk("hs.cnt5", 64'(pulse_cnt), 64'd0);
      if (k == 8) chk("hs.cnt8", 64'(pulse_cnt), 64'd1);
      start = (k == 2 || k == 4);
      if (k == 2) begin
        pattern = P4; pulse_len = 4'd1; repeat_n = 8'd1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
